// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite master between two native
// memory requesters, one transaction at a time, with a response watchdog.
`timescale 1ns/1ps
module axi_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p0_valid,
    input  logic        p0_instr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic        p0_ready,
    output logic [31:0] p0_rdata,
    input  logic        p1_valid,
    input  logic        p1_instr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic        p1_ready,
    output logic [31:0] p1_rdata,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    output logic        grant,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

    // One spare bit: a handshake on the expiry cycle pushes the count past the limit.
    localparam logic [16:0] CNT_MAX = 17'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic [16:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        bready_q, bready_d;
    logic        rready_q, rready_d;
    logic        p0_ready_q, p0_ready_d;
    logic        p1_ready_q, p1_ready_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        sel;
    logic        is_wr;
    logic        expired;
    logic        done;
    logic        timeout;
    logic [31:0] done_data;

    assign is_wr   = |wstrb_q;
    assign expired = cnt_q >= CNT_MAX;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        instr_d      = instr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        arvalid_d    = 1'b0;
        bready_d     = 1'b0;
        rready_d     = 1'b0;
        p0_ready_d   = 1'b0;
        p1_ready_d   = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        sel          = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        done_data    = '0;

        unique case (state_q)
            IDLE: begin
                if (p0_valid || p1_valid) begin
                    // On a tie the port not granted last time wins.
                    sel       = p1_valid & (~p0_valid | ~last_grant_q);
                    grant_d   = sel;
                    addr_d    = sel ? p1_addr  : p0_addr;
                    wdata_d   = sel ? p1_wdata : p0_wdata;
                    wstrb_d   = sel ? p1_wstrb : p0_wstrb;
                    instr_d   = sel ? p1_instr : p0_instr;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 17'd1;
                if (is_wr) begin
                    aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
                    w_done_d  = w_done_q | (wvalid_q & m_axi_wready);
                    if (aw_done_d && w_done_d) begin
                        bready_d = 1'b1;
                        state_d  = RESP;
                    end else if (expired) begin
                        timeout = 1'b1;
                    end else begin
                        awvalid_d = ~aw_done_d;
                        wvalid_d  = ~w_done_d;
                    end
                end else begin
                    if (arvalid_q && m_axi_arready) begin
                        rready_d = 1'b1;
                        state_d  = RESP;
                    end else if (expired) begin
                        timeout = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                cnt_d = cnt_q + 17'd1;
                if (bready_q && m_axi_bvalid) begin
                    done = 1'b1;
                end else if (rready_q && m_axi_rvalid) begin
                    done      = 1'b1;
                    done_data = m_axi_rdata;
                end else if (expired) begin
                    timeout = 1'b1;
                end else begin
                    bready_d = bready_q;
                    rready_d = rready_q;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort leaves the slave mid-transaction; used for board hang recovery.
        if (timeout) begin
            done      = 1'b1;
            done_data = TIMEOUT_RDATA;
            err_d     = 1'b1;
        end

        if (done) begin
            state_d    = DONE;
            p0_ready_d = ~grant_q;
            p1_ready_d = grant_q;
            if (grant_q) p1_rdata_d = done_data;
            else         p0_rdata_d = done_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            instr_q      <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            p0_ready_q   <= 1'b0;
            p1_ready_q   <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            instr_q      <= instr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            rready_q     <= rready_d;
            p0_ready_q   <= p0_ready_d;
            p1_ready_q   <= p1_ready_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    assign p0_ready      = p0_ready_q;
    assign p0_rdata      = p0_rdata_q;
    assign p1_ready      = p1_ready_q;
    assign p1_rdata      = p1_rdata_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = {instr_q, 2'b00};
    assign m_axi_rready  = rready_q;
    assign grant         = grant_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: latency, split write, round-robin,
// watchdog expiry and its boundary, and reset during a transaction.
`timescale 1ns/1ps
module tb_axi_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        p0_valid, p0_instr, p0_ready;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_wstrb;
    logic        p1_valid, p1_instr, p1_ready;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_wstrb;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic        grant, err_timeout;

    always #5 clk = ~clk;

    axi_mem_arbiter #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_RDATA (32'hDEADBEEF)
    ) dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(p0_valid), .p0_instr(p0_instr), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_instr(p1_instr), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata),
        .grant(grant), .err_timeout(err_timeout)
    );

    logic [178:0] all_out;
    assign all_out = {p0_ready, p0_rdata, p1_ready, p1_rdata,
                      m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
                      m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready,
                      m_axi_arvalid, m_axi_araddr, m_axi_arprot,
                      m_axi_rready, grant, err_timeout};

    int n_tests = 0;
    int n_fail  = 0;

    // Bus-side observations taken at each clock edge
    logic [31:0] ar_addr_seen, aw_addr_seen, w_data_seen;
    logic [2:0]  ar_prot_seen, aw_prot_seen;
    logic [3:0]  w_strb_seen;
    int          p0_pulses = 0;
    int          p1_pulses = 0;
    int          both_rdy  = 0;

    always @(posedge clk) begin
        if (m_axi_arvalid && m_axi_arready) begin
            ar_addr_seen <= m_axi_araddr;
            ar_prot_seen <= m_axi_arprot;
        end
        if (m_axi_awvalid && m_axi_awready) begin
            aw_addr_seen <= m_axi_awaddr;
            aw_prot_seen <= m_axi_awprot;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            w_data_seen <= m_axi_wdata;
            w_strb_seen <= m_axi_wstrb;
        end
        if (p0_ready) p0_pulses <= p0_pulses + 1;
        if (p1_ready) p1_pulses <= p1_pulses + 1;
        if (p0_ready && p1_ready) both_rdy <= both_rdy + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
    endtask

    // cyc = edges after the request edge; -1 if the budget ran out
    task automatic wait_ready(input int port, input int max_cyc,
                              output int cyc);
        cyc = -1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        p0_valid = 0; p0_instr = 0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_valid = 0; p1_instr = 0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
        idle_bus();
        tick();
        tick();
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        resetn = 1'b1;
        tick();
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs got %h exp 0", all_out);
        end
    endtask

    task automatic test_single_read();
        int cyc;
        int base;
        p0_addr = 32'h100; p0_instr = 1'b1; p0_wstrb = 4'h0;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 32'h12345678;
        base = p0_pulses;
        p0_valid = 1'b1;
        wait_ready(0, 20, cyc);
        n_tests++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL read_latency got %0d exp 3", cyc);
        end
        n_tests++;
        if (p0_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL read_rdata got %h exp 12345678", p0_rdata);
        end
        n_tests++;
        if ({ar_prot_seen, ar_addr_seen} !== {3'b100, 32'h100}) begin
            n_fail++;
            $display("FAIL read_ar got %b/%h exp 100/00000100",
                     ar_prot_seen, ar_addr_seen);
        end
        n_tests++;
        if ({grant, p1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_grant got %b exp 00", {grant, p1_ready});
        end
        p0_valid = 1'b0;
        p0_instr = 1'b0;
        tick();
        n_tests++;
        if (p0_ready !== 1'b0 || p0_pulses - base !== 1) begin
            n_fail++;
            $display("FAIL read_pulse got %b/%0d exp 0/1",
                     p0_ready, p0_pulses - base);
        end
        idle_bus();
        tick();
    endtask

    task automatic test_split_write();
        int rdy_e = -1;
        int base;
        p1_addr = 32'h2000; p1_wdata = 32'hCAFEF00D; p1_wstrb = 4'b0011;
        base = p1_pulses;
        p1_valid = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (p1_ready) begin
                rdy_e = e;
                break;
            end
            if (e == 1) begin
                n_tests++;
                if ({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr} !==
                    {2'b11, 32'h2000}) begin
                    n_fail++;
                    $display("FAIL wr_valids got %b%b/%h exp 11/00002000",
                             m_axi_awvalid, m_axi_wvalid, m_axi_awaddr);
                end
                m_axi_wready = 1'b1;
            end
            if (e == 2) begin
                n_tests++;
                if ({m_axi_awvalid, m_axi_wvalid} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL wr_wdrop got %b%b exp 10",
                             m_axi_awvalid, m_axi_wvalid);
                end
                m_axi_wready = 1'b0;
            end
            if (e == 3) m_axi_awready = 1'b1;
            if (e == 4) begin
                n_tests++;
                if ({m_axi_awvalid, m_axi_bready} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL wr_resp got %b%b exp 01",
                             m_axi_awvalid, m_axi_bready);
                end
                m_axi_awready = 1'b0;
            end
            if (e == 6) m_axi_bvalid = 1'b1;
        end
        n_tests++;
        if (rdy_e !== 7) begin
            n_fail++;
            $display("FAIL wr_latency got %0d exp 7", rdy_e);
        end
        n_tests++;
        if ({grant, p1_rdata, p0_ready} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_done got %b/%h/%b exp 1/00000000/0",
                     grant, p1_rdata, p0_ready);
        end
        n_tests++;
        if ({w_strb_seen, w_data_seen, aw_addr_seen, aw_prot_seen} !==
            {4'b0011, 32'hCAFEF00D, 32'h2000, 3'b000}) begin
            n_fail++;
            $display("FAIL wr_slave got %b/%h/%h/%b exp 0011/cafef00d/00002000/000",
                     w_strb_seen, w_data_seen, aw_addr_seen, aw_prot_seen);
        end
        p1_valid = 1'b0;
        idle_bus();
        tick();
        n_tests++;
        if (p1_ready !== 1'b0 || p1_pulses - base !== 1) begin
            n_fail++;
            $display("FAIL wr_pulse got %b/%0d exp 0/1",
                     p1_ready, p1_pulses - base);
        end
        p1_wstrb = 4'b0;
        tick();
    endtask

    task automatic test_contention();
        int seq[8];
        int n = 0;
        int hold0 = 0, hold1 = 0;
        int cnt0 = 0, cnt1 = 0;
        int base_both;
        int exp_port;
        base_both = both_rdy;
        p0_addr = 32'h10; p1_addr = 32'h20;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 32'h11112222;
        p0_valid = 1'b1;
        p1_valid = 1'b1;
        for (int c = 0; c < 100 && n < 6; c++) begin
            tick();
            if (p0_ready) begin
                if (n < 8) seq[n] = 0;
                n++; cnt0++;
                p0_valid = 1'b0;
                hold0 = 2;
            end else if (hold0 > 0) begin
                hold0--;
                if (hold0 == 0 && cnt0 < 3) p0_valid = 1'b1;
            end
            if (p1_ready) begin
                if (n < 8) seq[n] = 1;
                n++; cnt1++;
                p1_valid = 1'b0;
                hold1 = 2;
            end else if (hold1 > 0) begin
                hold1--;
                if (hold1 == 0 && cnt1 < 3) p1_valid = 1'b1;
            end
        end
        n_tests++;
        if (n !== 6) begin
            n_fail++;
            $display("FAIL rr_count got %0d exp 6", n);
        end
        for (int i = 0; i < 6 && i < n; i++) begin
            exp_port = i % 2;
            n_tests++;
            if (seq[i] !== exp_port) begin
                n_fail++;
                $display("FAIL rr_seq[%0d] got %0d exp %0d", i, seq[i], exp_port);
            end
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        idle_bus();
        tick();
        tick();
        n_tests++;
        if (both_rdy - base_both !== 0) begin
            n_fail++;
            $display("FAIL rr_overlap got %0d exp 0", both_rdy - base_both);
        end
    endtask

    task automatic test_timeout_boundary();
        int rdy_e = -1;
        p0_addr = 32'h400; p0_instr = 1'b0; p0_wstrb = 4'h0;
        m_axi_arready = 1'b1;
        m_axi_rdata   = 32'h5A5A1234;
        p0_valid = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (p0_ready) begin
                rdy_e = e;
                break;
            end
            if (e == 8) m_axi_rvalid = 1'b1;
        end
        n_tests++;
        if (rdy_e !== 9) begin
            n_fail++;
            $display("FAIL tb_latency got %0d exp 9", rdy_e);
        end
        n_tests++;
        if ({p0_rdata, err_timeout} !== {32'h5A5A1234, 1'b0}) begin
            n_fail++;
            $display("FAIL tb_data got %h/%b exp 5a5a1234/0",
                     p0_rdata, err_timeout);
        end
        p0_valid = 1'b0;
        idle_bus();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int rdy_e = -1;
        int arv = 0;
        p0_addr = 32'h300; p0_instr = 1'b1; p0_wstrb = 4'h0;
        p0_valid = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (m_axi_arvalid) arv++;
            if (p0_ready) begin
                rdy_e = e;
                break;
            end
        end
        n_tests++;
        if (rdy_e !== 9 || arv !== 8) begin
            n_fail++;
            $display("FAIL to_timing got edge %0d/arvalid %0d exp 9/8",
                     rdy_e, arv);
        end
        n_tests++;
        if ({p0_rdata, err_timeout, m_axi_arvalid, m_axi_rready} !==
            {32'hDEADBEEF, 3'b100}) begin
            n_fail++;
            $display("FAIL to_done got %h/%b%b%b exp deadbeef/100",
                     p0_rdata, err_timeout, m_axi_arvalid, m_axi_rready);
        end
        p0_valid = 1'b0;
        p0_instr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky got %b exp 1", err_timeout);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        int base;
        p0_addr = 32'h500; p0_wdata = 32'h11223344; p0_wstrb = 4'hF;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        p0_valid = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if (m_axi_bready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre got bready %b exp 1", m_axi_bready);
        end
        idle_bus();
        tick();
        base = p0_pulses;
        resetn = 1'b0;
        p0_valid = 1'b0;
        p0_wstrb = 4'h0;
        tick();
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL rst_mid got %h exp 0", all_out);
        end
        tick();
        resetn = 1'b1;
        tick();
        tick();
        n_tests++;
        if (p0_pulses - base !== 0) begin
            n_fail++;
            $display("FAIL rst_nopulse got %0d exp 0", p0_pulses - base);
        end
        p1_addr = 32'h600; p1_instr = 1'b0; p1_wstrb = 4'h0;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 32'h0BADC0DE;
        p1_valid = 1'b1;
        wait_ready(1, 20, cyc);
        n_tests++;
        if (cyc !== 3 || p1_rdata !== 32'h0BADC0DE || grant !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after got %0d/%h/%b exp 3/0badc0de/1",
                     cyc, p1_rdata, grant);
        end
        p1_valid = 1'b0;
        idle_bus();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_split_write();
        test_contention();
        test_timeout_boundary();
        test_timeout();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
